// File: rtl/rc5_feeder_pkg.sv
// Shared types and sizing for the RC5 byte-stream feeder.
package rc5_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEY_COLLECT,
    KEY_LOAD,
    KEY_WAIT,
    DATA_COLLECT,
    ISSUE,
    WAIT_RESULT
  } state_t;

  localparam int KEY_BYTES = 16;
  localparam int BLK_BYTES = 8;

  // Width of a counter that must reach timeout-1.
  function automatic int to_width(input int timeout);
    return (timeout < 3) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/rc5_byte_shifter.sv
// MSB-first byte shift register with a count of bytes loaded since the last clear.
module rc5_byte_shifter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH / 8 + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  // clr only resets the count so the held value stays visible downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (shift_en) begin
      data  <= {data[WIDTH-9:0], byte_in};
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rc5_feeder.sv
// Collects a 16-byte key and 8-byte blocks from a byte stream and drives an rc5_core.
// Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both high.
module rc5_feeder
  import rc5_feeder_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_start,
  input  logic         mode,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic [127:0] key,
  output logic         key_en,
  input  logic         key_ok,
  output logic         flag,
  output logic [63:0]  din,
  output logic         din_en,
  input  logic         dout_en,
  output logic         busy,
  output logic         err,
  output logic [15:0]  blk_cnt,
  output logic [2:0]   state_dbg
);

  localparam int TW  = to_width(TIMEOUT);
  localparam int KCW = $clog2(KEY_BYTES + 1);
  localparam int DCW = $clog2(BLK_BYTES + 1);

  state_t         state;
  logic [TW-1:0]  to_cnt;
  logic [KCW-1:0] key_cnt;
  logic [DCW-1:0] din_cnt;
  logic           accept;
  logic           ks_acc;
  logic           key_shift;
  logic           din_shift;
  logic           din_clr;
  logic           timeout_hit;

  assign accept      = byte_valid & byte_ready;
  assign ks_acc      = key_start & ((state == IDLE) | ((state == DATA_COLLECT) & (din_cnt == '0)));
  assign key_shift   = accept & (state == KEY_COLLECT);
  // A simultaneous key_start at zero bytes takes priority over the data byte.
  assign din_shift   = accept & (state == DATA_COLLECT) & ~ks_acc;
  assign din_clr     = ks_acc | (state == ISSUE);
  assign timeout_hit = (to_cnt == TW'(TIMEOUT - 1));

  assign byte_ready = (state == KEY_COLLECT) | (state == DATA_COLLECT);
  assign key_en     = (state == KEY_LOAD);
  assign din_en     = (state == ISSUE);
  assign busy       = ~((state == IDLE) | ((state == DATA_COLLECT) & (din_cnt == '0)));
  assign state_dbg  = state;

  rc5_byte_shifter #(.WIDTH(8 * KEY_BYTES), .CNT_W(KCW)) u_key_shifter (
    .clk      (clk),
    .rst      (rst),
    .clr      (ks_acc),
    .shift_en (key_shift),
    .byte_in  (byte_in),
    .data     (key),
    .count    (key_cnt)
  );

  rc5_byte_shifter #(.WIDTH(8 * BLK_BYTES), .CNT_W(DCW)) u_din_shifter (
    .clk      (clk),
    .rst      (rst),
    .clr      (din_clr),
    .shift_en (din_shift),
    .byte_in  (byte_in),
    .data     (din),
    .count    (din_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      to_cnt  <= '0;
      err     <= 1'b0;
      flag    <= 1'b0;
      blk_cnt <= '0;
    end else if (ks_acc) begin
      err     <= 1'b0;
      blk_cnt <= '0;
      state   <= KEY_COLLECT;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        KEY_COLLECT: begin
          if (key_shift && key_cnt == KCW'(KEY_BYTES - 1)) state <= KEY_LOAD;
        end
        KEY_LOAD: begin
          to_cnt <= '0;
          state  <= KEY_WAIT;
        end
        KEY_WAIT: begin
          if (key_ok) begin
            state <= DATA_COLLECT;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DATA_COLLECT: begin
          if (din_shift && din_cnt == DCW'(BLK_BYTES - 1)) begin
            flag  <= mode;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt <= '0;
          state  <= WAIT_RESULT;
        end
        WAIT_RESULT: begin
          if (dout_en) begin
            blk_cnt <= blk_cnt + 16'd1;
            state   <= DATA_COLLECT;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_feeder.sv
// Randomized bench for rc5_feeder with a queue-based scoreboard for key and block issue.
module tb_rc5_feeder;
  import rc5_feeder_pkg::*;

  localparam int TIMEOUT = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_start = 1'b0;
  logic         mode = 1'b0;
  logic [7:0]   byte_in = 8'h00;
  logic         byte_valid = 1'b0;
  logic         key_ok = 1'b0;
  logic         dout_en = 1'b0;
  logic         byte_ready, key_en, flag, din_en, busy, err;
  logic [127:0] key;
  logic [63:0]  din;
  logic [15:0]  blk_cnt;
  logic [2:0]   state_dbg;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_key_q[$];
  logic [64:0]  exp_blk_q[$];
  logic [15:0]  model_cnt = 16'h0000;
  logic [63:0]  last_din = 64'h0;
  logic         prev_key_en = 1'b0;
  logic         prev_din_en = 1'b0;

  rc5_feeder #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_start  (key_start),
    .mode       (mode),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .key        (key),
    .key_en     (key_en),
    .key_ok     (key_ok),
    .flag       (flag),
    .din        (din),
    .din_en     (din_en),
    .dout_en    (dout_en),
    .busy       (busy),
    .err        (err),
    .blk_cnt    (blk_cnt),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key"}, key, 128'(0));
    check({tag, "_din"}, 128'(din), 128'(0));
    check({tag, "_flag"}, 128'(flag), 128'(0));
    check({tag, "_key_en"}, 128'(key_en), 128'(0));
    check({tag, "_din_en"}, 128'(din_en), 128'(0));
    check({tag, "_byte_ready"}, 128'(byte_ready), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_err"}, 128'(err), 128'(0));
    check({tag, "_blk_cnt"}, 128'(blk_cnt), 128'(0));
    check({tag, "_state"}, 128'(state_dbg), 128'(IDLE));
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic m);
    int n;
    n = 0;
    if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
    byte_in = b;
    mode = m;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      tick();
      n++;
    end
    check("byte_ready_wait", 128'(byte_ready), 128'(1));
    tick();
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
    mode = 1'($urandom);
  endtask

  // ok_delay < 0 withholds key_ok; returns in the key_en cycle in that case.
  task automatic load_key(input logic [127:0] k, input int ok_delay, input bit do_start);
    if (do_start) begin
      key_start = 1'b1;
      tick();
      key_start = 1'b0;
      model_cnt = 16'h0000;
      check("ks_state", 128'(state_dbg), 128'(KEY_COLLECT));
      check("ks_err_clear", 128'(err), 128'(0));
      check("ks_blk_cnt_clear", 128'(blk_cnt), 128'(0));
    end
    exp_key_q.push_back(k);
    for (int i = 0; i < KEY_BYTES; i++) send_byte(k[127 - 8 * i -: 8], 1'($urandom));
    check("key_load_state", 128'(state_dbg), 128'(KEY_LOAD));
    if (ok_delay >= 0) begin
      tick(ok_delay);
      key_ok = 1'b1;
      tick();
      key_ok = 1'b0;
      check("key_ok_state", 128'(state_dbg), 128'(DATA_COLLECT));
      check("key_ok_busy", 128'(busy), 128'(0));
      check("key_ok_ready", 128'(byte_ready), 128'(1));
      check("key_stable", key, k);
    end
  endtask

  task automatic send_data(input logic [63:0] d, input logic m);
    exp_blk_q.push_back({m, d});
    for (int i = 0; i < BLK_BYTES; i++) send_byte(d[63 - 8 * i -: 8], (i == BLK_BYTES - 1) ? m : 1'($urandom));
    check("din_en_timing", 128'(din_en), 128'(1));
  endtask

  task automatic send_block(input logic [63:0] d, input logic m, input int dly,
                            input bit ks_in_wait, input bit junk_in_wait);
    send_data(d, m);
    tick();
    check("wait_state", 128'(state_dbg), 128'(WAIT_RESULT));
    check("wait_ready", 128'(byte_ready), 128'(0));
    if (ks_in_wait) begin
      key_start = 1'b1;
      tick();
      key_start = 1'b0;
      check("ks_ignored_state", 128'(state_dbg), 128'(WAIT_RESULT));
    end
    if (junk_in_wait) begin
      byte_valid = 1'b1;
      byte_in = 8'($urandom);
    end
    tick(dly);
    check("din_stable", 128'(din), 128'(d));
    check("flag_stable", 128'(flag), 128'(m));
    dout_en = 1'b1;
    tick();
    dout_en = 1'b0;
    byte_valid = 1'b0;
    model_cnt = model_cnt + 16'd1;
    last_din = d;
    check("blk_cnt", 128'(blk_cnt), 128'(model_cnt));
    check("ready_after_result", 128'(byte_ready), 128'(1));
    check("idle_busy", 128'(busy), 128'(0));
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (key_en || din_en) check("en_exclusive", 128'(key_en & din_en), 128'(0));
      if (key_en) begin
        check("key_en_single", 128'(prev_key_en), 128'(0));
        check("key_en_expected", 128'(key_en), 128'(exp_key_q.size() != 0));
        if (exp_key_q.size() != 0) check("key_value", key, exp_key_q.pop_front());
      end
      if (din_en) begin
        check("din_en_single", 128'(prev_din_en), 128'(0));
        check("din_en_expected", 128'(din_en), 128'(exp_blk_q.size() != 0));
        if (exp_blk_q.size() != 0) check("block_value", 128'({flag, din}), 128'(exp_blk_q.pop_front()));
      end
      prev_key_en = key_en;
      prev_din_en = din_en;
    end
  end

  // main sequence
  initial begin
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    tick(2);
    rst = 1'b1;
    tick();
    check("post_release_state", 128'(state_dbg), 128'(IDLE));

    load_key(128'h000102030405060708090a0b0c0d0e0f, 3, 1'b1);

    // Stray handshakes outside their wait states.
    key_ok = 1'b1;
    tick();
    key_ok = 1'b0;
    check("stray_key_ok", 128'(state_dbg), 128'(DATA_COLLECT));
    dout_en = 1'b1;
    tick();
    dout_en = 1'b0;
    check("stray_dout_en", 128'(blk_cnt), 128'(model_cnt));

    send_block(64'h1122334455667788, 1'b1, 2, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      send_block({$urandom, $urandom}, 1'($urandom), $urandom_range(0, 3), i == 2, i == 4);

    // blk_cnt wrap.
    force dut.blk_cnt = 16'hfffe;
    tick();
    release dut.blk_cnt;
    model_cnt = 16'hfffe;
    tick();
    check("blk_preset", 128'(blk_cnt), 128'(model_cnt));
    send_block({$urandom, $urandom}, 1'($urandom), 1, 1'b0, 1'b0);
    send_block({$urandom, $urandom}, 1'($urandom), 0, 1'b0, 1'b0);
    check("blk_wrapped", 128'(blk_cnt), 128'(16'h0000));

    // key_start and a data byte together at zero bytes: key path wins.
    key_start = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'haa;
    tick();
    key_start = 1'b0;
    byte_valid = 1'b0;
    model_cnt = 16'h0000;
    check("ks_vs_byte_state", 128'(state_dbg), 128'(KEY_COLLECT));
    check("ks_vs_byte_din", 128'(din), 128'(last_din));
    check("ks_vs_byte_blk_cnt", 128'(blk_cnt), 128'(0));
    load_key({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
    send_block({$urandom, $urandom}, 1'($urandom), 2, 1'b0, 1'b0);

    // WAIT_RESULT timeout.
    send_data({$urandom, $urandom}, 1'($urandom));
    tick(TIMEOUT);
    check("wr_pre_timeout_err", 128'(err), 128'(0));
    check("wr_pre_timeout_state", 128'(state_dbg), 128'(WAIT_RESULT));
    tick();
    check("wr_timeout_err", 128'(err), 128'(1));
    check("wr_timeout_state", 128'(state_dbg), 128'(IDLE));
    dout_en = 1'b1;
    tick();
    dout_en = 1'b0;
    check("late_dout_en", 128'(blk_cnt), 128'(model_cnt));

    // KEY_WAIT timeout, then key_start clears err.
    load_key({$urandom, $urandom, $urandom, $urandom}, -1, 1'b1);
    tick(TIMEOUT);
    check("kw_pre_timeout_err", 128'(err), 128'(0));
    check("kw_pre_timeout_state", 128'(state_dbg), 128'(KEY_WAIT));
    tick();
    check("kw_timeout_err", 128'(err), 128'(1));
    check("kw_timeout_state", 128'(state_dbg), 128'(IDLE));
    check("kw_timeout_busy", 128'(busy), 128'(0));
    key_ok = 1'b1;
    tick();
    key_ok = 1'b0;
    check("late_key_ok", 128'(state_dbg), 128'(IDLE));
    load_key({$urandom, $urandom, $urandom, $urandom}, 2, 1'b1);
    send_block({$urandom, $urandom}, 1'($urandom), 1, 1'b0, 1'b0);

    // Reset mid-block after the 5th data byte.
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'($urandom));
    check("partial_busy", 128'(busy), 128'(1));
    rst = 1'b0;
    #1 check_all_zero("mid_reset");
    tick(3);
    rst = 1'b1;
    tick(12);
    check("post_abandon_state", 128'(state_dbg), 128'(IDLE));

    check("key_q_empty", 128'(exp_key_q.size()), 128'(0));
    check("blk_q_empty", 128'(exp_blk_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
